ahb_reg_bank: RTL and testbench

- Parametrised AHB-Lite slave exposing NUM_REGS 32-bit read/write registers as flat output bus `regs_out`.
- Generalises the fixed three-register SoC export (register_0..2).
- Adds:
  - arbitrary register count
  - byte/halfword write strobes
  - programmable wait-state insertion
  - optional two-cycle ERROR response for unmapped offsets
- Sits on the SoC AHB-Lite decoder as one slave; `regs_out` feeds peripherals/top-level observation.

---
 rtl/ahb_reg_bank.sv | 173 +++++++++++++++++
 tb/tb_ahb_reg_bank.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_reg_bank.sv
// ahb_reg_bank: AHB-Lite slave exposing NUM_REGS 32-bit read/write registers.
//
// Adds byte/halfword write strobes, WAIT_STATES extra data-phase cycles per
// accepted transfer, and an optional two-cycle ERROR response for offsets
// beyond the last register.
//
// Build option: define AHB_REG_BANK_ERR_EN to answer unmapped offsets with
// ERROR. Without it, unmapped accesses complete OKAY, writes are dropped and
// reads return 0.
//
// Ports:
//   HCLK, HRESETn        bus clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS  address phase (only HADDR[ADDR_W-1:0] decoded)
//   HWRITE, HSIZE        direction and size (HSIZE > 2 treated as word)
//   HWDATA               write data (data phase)
//   HREADY               bus-level ready
//   HRDATA               read data, non-zero only in a completing read
//   HREADYOUT, HRESP     slave ready / response
//   regs_out             register i at [32*i+31:32*i]
//
// State | meaning
// IDLE  | no data phase pending, ready
// DATA  | data phase, counting down wait states; completes at count 0
// ERR1  | first ERROR cycle, HREADYOUT low (AHB_REG_BANK_ERR_EN only)
// ERR2  | second ERROR cycle, HREADYOUT high (AHB_REG_BANK_ERR_EN only)

module ahb_reg_bank #(
    parameter int          NUM_REGS    = 4,
    parameter int          ADDR_W      = 8,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] RESET_VAL   = 32'h0000_0000
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    HSEL,
    input  logic [31:0]             HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [31:0]             HWDATA,
    input  logic                    HREADY,
    output logic [31:0]             HRDATA,
    output logic                    HREADYOUT,
    output logic                    HRESP,
    output logic [32*NUM_REGS-1:0]  regs_out
);

    localparam int         IDX_W = ADDR_W - 2;
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

`ifdef AHB_REG_BANK_ERR_EN
    typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;

    function automatic logic is_mapped(input logic [ADDR_W-1:0] a);
        return {1'b0, a[ADDR_W-1:2]} < (IDX_W+1)'(NUM_REGS);
    endfunction
`else
    typedef enum logic {IDLE, DATA} state_t;
`endif

    state_t            state_q, state_d, accept_tgt;
    logic [31:0]       regs [NUM_REGS];
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [2:0]        size_q;
    logic [3:0]        cnt_q;
    logic [3:0]        strb;
    logic              accept;
    logic              complete;
    logic              unused_bits;

    assign unused_bits = ^{HADDR, HTRANS[0]};

    // HREADYOUT gates acceptance so a new address is only taken while this
    // slave is ready, matching what the bus-level HREADY will show.
    assign accept   = HSEL & HREADY & HTRANS[1] & HREADYOUT;
    assign complete = (state_q == DATA) && (cnt_q == 4'd0);

`ifdef AHB_REG_BANK_ERR_EN
    assign accept_tgt = is_mapped(HADDR[ADDR_W-1:0]) ? DATA : ERR1;
`else
    assign accept_tgt = DATA;
`endif

    // state register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = accept_tgt;
            DATA: if (cnt_q == 4'd0) state_d = accept ? accept_tgt : IDLE;
`ifdef AHB_REG_BANK_ERR_EN
            ERR1: state_d = ERR2;
            ERR2: state_d = accept ? accept_tgt : IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // outputs
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = 32'h0;
        case (state_q)
            DATA: HREADYOUT = (cnt_q == 4'd0);
`ifdef AHB_REG_BANK_ERR_EN
            ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            ERR2: HRESP = 1'b1;
`endif
            default: ;
        endcase
        // unmapped indices match no register and therefore read as 0
        if (complete && !write_q) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (addr_q[ADDR_W-1:2] == IDX_W'(i)) HRDATA = regs[i];
            end
        end
    end

    // data-phase capture and wait counter
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
            cnt_q   <= 4'd0;
        end else if (accept) begin
            addr_q  <= HADDR[ADDR_W-1:0];
            write_q <= HWRITE;
            size_q  <= HSIZE;
            cnt_q   <= WS;
        end else if (state_q == DATA && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // little-endian lane enables; unaligned accesses fall back to aligned lanes
    always_comb begin
        case (size_q)
            3'd0:    strb = 4'b0001 << addr_q[1:0];
            3'd1:    strb = addr_q[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
        end else if (complete && write_q) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (addr_q[ADDR_W-1:2] == IDX_W'(i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (strb[b]) regs[i][8*b +: 8] <= HWDATA[8*b +: 8];
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign regs_out[32*g +: 32] = regs[g];
    end

endmodule

// File: tb/tb_ahb_reg_bank.sv
// Bench for ahb_reg_bank: a zero-wait instance and a two-wait instance share
// one AHB master; HREADY is muxed from whichever instance is selected.
module tb_ahb_reg_bank;

    logic HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    logic         HRESETn;
    logic         hsel, sel_ws;
    logic [31:0]  haddr, hwdata;
    logic [1:0]   htrans;
    logic         hwrite;
    logic [2:0]   hsize;

    logic [31:0]  rdata0, rdata2;
    logic         ro0, ro2, resp0, resp2;
    logic [127:0] regs0, regs2;

    logic         hready, rresp;
    logic [31:0]  rdata;
    logic [127:0] regs_sel;
    assign hready   = sel_ws ? ro2    : ro0;
    assign rresp    = sel_ws ? resp2  : resp0;
    assign rdata    = sel_ws ? rdata2 : rdata0;
    assign regs_sel = sel_ws ? regs2  : regs0;

    ahb_reg_bank #(.NUM_REGS(4), .ADDR_W(8), .WAIT_STATES(0), .RESET_VAL(32'h0)) u_dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel & ~sel_ws), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
        .HREADY(hready), .HRDATA(rdata0), .HREADYOUT(ro0), .HRESP(resp0),
        .regs_out(regs0));

    ahb_reg_bank #(.NUM_REGS(4), .ADDR_W(8), .WAIT_STATES(2), .RESET_VAL(32'h0)) u_dut2 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel & sel_ws), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
        .HREADY(hready), .HRDATA(rdata2), .HREADYOUT(ro2), .HRESP(resp2),
        .regs_out(regs2));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct {
        string       name;
        logic        rd;
        logic [31:0] rdata;
        logic        resp;
        int          waits;
        int          hold_idx;
        logic [31:0] hold_val;
    } exp_t;

    xfer_t xq[$];
    exp_t  exp_q[$];

    task automatic add(input string name, input logic wr, input logic [31:0] addr,
                       input logic [2:0] size, input logic [31:0] wdata,
                       input logic [31:0] rdata_e, input logic resp_e, input int waits_e,
                       input int hold_idx, input logic [31:0] hold_val);
        xfer_t x;
        exp_t  e;
        x.wr = wr; x.addr = addr; x.size = size; x.wdata = wdata;
        e.name = name; e.rd = !wr; e.rdata = rdata_e; e.resp = resp_e;
        e.waits = waits_e; e.hold_idx = hold_idx; e.hold_val = hold_val;
        xq.push_back(x);
        exp_q.push_back(e);
    endtask

    // Pipelined master: address of transfer k goes out with write data of k-1.
    task automatic run_seq();
        xfer_t prev;
        logic  have_prev;
        logic  r;
        int    guard;
        int    n;
        have_prev = 1'b0;
        n = xq.size();
        for (int k = 0; k <= n; k++) begin
            if (k < n) begin
                hsel = 1'b1; htrans = 2'b10; haddr = xq[k].addr;
                hwrite = xq[k].wr; hsize = xq[k].size;
            end else begin
                htrans = 2'b00;
            end
            hwdata = have_prev ? prev.wdata : 32'h0;
            guard = 0;
            do begin
                @(negedge HCLK);
                r = hready;
                @(posedge HCLK);
                #1;
                guard++;
            end while (!r && guard < 20);
            if (!r) begin
                n_chk++; n_err++;
                $display("FAIL timeout: HREADY low for %0d cycles, required high", guard);
            end
            if (k < n) begin
                prev = xq[k];
                have_prev = 1'b1;
            end
        end
        xq.delete();
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'h0;
    endtask

    // Bus-side tracking of an outstanding data phase.
    logic dph;
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)   dph <= 1'b0;
        else if (hready) dph <= hsel && htrans[1];
    end

    int   waits_seen;
    logic resp_bad, hold_bad;
    exp_t head;

    always @(negedge HCLK) begin
        if (!HRESETn) begin
            waits_seen = 0; resp_bad = 1'b0; hold_bad = 1'b0;
        end else if (dph) begin
            if (exp_q.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL unexpected_response: got data phase, expected none");
            end else begin
                head = exp_q[0];
                if (rresp !== head.resp) resp_bad = 1'b1;
                if (head.hold_idx >= 0 && regs_sel[32*head.hold_idx +: 32] !== head.hold_val)
                    hold_bad = 1'b1;
                if (!hready) begin
                    waits_seen++;
                end else begin
                    head = exp_q.pop_front();
                    chk({head.name, "_waits"}, waits_seen, head.waits);
                    chk({head.name, "_resp_all_cycles_bad"}, {31'b0, resp_bad}, 32'd0);
                    if (head.rd) chk({head.name, "_rdata"}, rdata, head.rdata);
                    if (head.hold_idx >= 0)
                        chk({head.name, "_early_update"}, {31'b0, hold_bad}, 32'd0);
                    waits_seen = 0; resp_bad = 1'b0; hold_bad = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    localparam logic UNM_RESP  =
`ifdef AHB_REG_BANK_ERR_EN
        1'b1;
`else
        1'b0;
`endif
    localparam int UNM_WAITS = UNM_RESP ? 1 : 0;

    initial begin
        HRESETn = 1'b0; hsel = 1'b0; sel_ws = 1'b0; haddr = 32'h0;
        htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2; hwdata = 32'h0;

        repeat (3) @(posedge HCLK);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_d0_reg%0d", i), regs0[32*i +: 32], 32'h0);
            chk($sformatf("rst_d2_reg%0d", i), regs2[32*i +: 32], 32'h0);
        end
        chk("rst_hreadyout", {31'b0, ro0}, 32'd1);
        chk("rst_hresp",     {31'b0, resp0}, 32'd0);
        chk("rst_hrdata",    rdata0, 32'h0);
        @(posedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        chk("post_rst_hreadyout", {31'b0, ro0}, 32'd1);
        chk("post_rst_hresp",     {31'b0, resp0}, 32'd0);

        // word write then back-to-back read
        add("w04", 1'b1, 32'h04, 3'd2, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, 1, 32'h0);
        add("r04", 1'b0, 32'h04, 3'd2, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, -1, 32'h0);
        run_seq();
        chk("reg1_word", regs0[32 +: 32], 32'hDEAD_BEEF);

        // byte then halfword strobes, then a byte-size read returns full word
        add("wb05", 1'b1, 32'h05, 3'd0, 32'h0000_AA00, 32'h0, 1'b0, 0, 1, 32'hDEAD_BEEF);
        add("wh06", 1'b1, 32'h06, 3'd1, 32'h1234_0000, 32'h0, 1'b0, 0, 1, 32'hDEAD_AAEF);
        add("rb07", 1'b0, 32'h07, 3'd0, 32'h0, 32'h1234_AAEF, 1'b0, 0, -1, 32'h0);
        run_seq();
        chk("reg1_strobes", regs0[32 +: 32], 32'h1234_AAEF);

        // HSIZE above word size behaves as word
        add("w0c_sz3", 1'b1, 32'h0C, 3'd3, 32'hCAFE_F00D, 32'h0, 1'b0, 0, 3, 32'h0);
        add("r0c",     1'b0, 32'h0C, 3'd2, 32'h0, 32'hCAFE_F00D, 1'b0, 0, -1, 32'h0);
        run_seq();
        chk("reg3_sz3", regs0[96 +: 32], 32'hCAFE_F00D);

        // IDLE and BUSY with HSEL high: zero-wait OKAY, nothing written
        hsel = 1'b1; haddr = 32'h04; hwrite = 1'b1; hsize = 3'd2; hwdata = 32'hFFFF_FFFF;
        htrans = 2'b00;
        @(posedge HCLK); #1;
        chk("idle_hreadyout", {31'b0, ro0}, 32'd1);
        chk("idle_hresp",     {31'b0, resp0}, 32'd0);
        htrans = 2'b01;
        @(posedge HCLK); #1;
        @(posedge HCLK); #1;
        chk("busy_hreadyout", {31'b0, ro0}, 32'd1);
        chk("busy_reg1",      regs0[32 +: 32], 32'h1234_AAEF);
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'h0;

        // unmapped offset 0x10 (index 4)
        add("w10", 1'b1, 32'h10, 3'd2, 32'hFFFF_FFFF, 32'h0, UNM_RESP, UNM_WAITS, -1, 32'h0);
        add("r10", 1'b0, 32'h10, 3'd2, 32'h0, 32'h0, UNM_RESP, UNM_WAITS, -1, 32'h0);
        run_seq();
        chk("unm_reg0", regs0[0  +: 32], 32'h0);
        chk("unm_reg1", regs0[32 +: 32], 32'h1234_AAEF);
        chk("unm_reg2", regs0[64 +: 32], 32'h0);
        chk("unm_reg3", regs0[96 +: 32], 32'hCAFE_F00D);

        // two wait states
        sel_ws = 1'b1;
        add("ws_w08", 1'b1, 32'h08, 3'd2, 32'h55AA_55AA, 32'h0, 1'b0, 2, 2, 32'h0);
        add("ws_r08", 1'b0, 32'h08, 3'd2, 32'h0, 32'h55AA_55AA, 1'b0, 2, -1, 32'h0);
        run_seq();
        chk("ws_reg2",       regs2[64 +: 32], 32'h55AA_55AA);
        chk("ws_d0_isolate", regs0[64 +: 32], 32'h0);

        // reset during second wait cycle of a write to 0x0C
        add("rst_abort", 1'b1, 32'h0C, 3'd2, 32'h1357_9BDF, 32'h0, 1'b0, 2, 3, 32'h0);
        xq.delete();
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h0C; hwrite = 1'b1; hsize = 3'd2;
        @(posedge HCLK); #1;
        htrans = 2'b00; hsel = 1'b0; hwdata = 32'h1357_9BDF;
        chk("abort_wait1_hreadyout", {31'b0, ro2}, 32'd0);
        @(posedge HCLK); #1;
        chk("abort_wait2_hreadyout", {31'b0, ro2}, 32'd0);
        #2 HRESETn = 1'b0;
        #1;
        exp_q.delete();
        chk("abort_reg3",       regs2[96 +: 32], 32'h0);
        chk("abort_hreadyout",  {31'b0, ro2}, 32'd1);
        chk("abort_hresp",      {31'b0, resp2}, 32'd0);
        @(posedge HCLK);
        HRESETn = 1'b1;
        hwdata = 32'h0;
        repeat (3) @(posedge HCLK);
        #1;
        chk("after_abort_reg3",      regs2[96 +: 32], 32'h0);
        chk("after_abort_reg2",      regs2[64 +: 32], 32'h0);
        chk("after_abort_hreadyout", {31'b0, ro2}, 32'd1);

        add("post_r0c", 1'b0, 32'h0C, 3'd2, 32'h0, 32'h0, 1'b0, 2, -1, 32'h0);
        run_seq();

        repeat (2) @(posedge HCLK);
        #1;
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
